jtframe_68kdma_copy: RTL and testbench
======================================

// Module: jtframe_68kdma_copy
// PURPOSE
//  DMA block-copy master for 68000-based cores. Takes a start command (source, destination,
//  word count), raises a bus request to the 68k bus arbiter and waits for the arbiter to report
//  bus ownership. It then copies words source->destination over the shared memory bus and drops
//  the request. Sits upstream of the arbiter: drives its dev_br bit and consumes its BGACKn.
// PARAMETERS
//  AW      23  word-address width (68k A23..A1)
//  DW      16  data width
//  LW      12  word-count width
//  BURST   64  max words copied per bus tenure; then bus is released so the CPU can run (>=1)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active high
//  cen        in   1   clock enable; all state advances only when cen=1
//  start      in   1   one-cen pulse: latch src/dst/len and begin; ignored while busy=1
//  src        in   AW  source word address
//  dst        in   AW  destination word address
//  len        in   LW  words to copy; 0 = no transfer
//  busy       out  1   high from accepted start until done
//  done       out  1   one-cen pulse when the copy completes
//  dev_br     out  1   bus request to the arbiter
//  cpu_BGACKn in   1   arbiter's bus-grant-acknowledge; 0 = this master owns the bus
//  mem_addr   out  AW  memory word address
//  mem_dout   out  DW  write data
//  mem_din    in   DW  read data, valid when mem_ok=1 during a read
//  mem_cs     out  1   cycle strobe; held until mem_ok
//  mem_rnw    out  1   1 = read, 0 = write
//  mem_ok     in   1   cycle completion; sampled on cen
// BEHAVIOUR
//  Reset (async, any state): busy=0, done=0, dev_br=0, mem_cs=0, mem_rnw=1, mem_addr=0,
//   mem_dout=0, internal pointers/counters=0, state=IDLE. Reset mid-copy abandons it silently.
//  States: IDLE, REQ, RD, WR, REL, FIN.
//  IDLE: on start: latch src,dst,len; busy=1. len==0 -> FIN directly (no bus request), else REQ.
//  REQ: dev_br=1. When cpu_BGACKn==0 -> RD; tenure counter cleared.
//  RD: mem_cs=1, mem_rnw=1, mem_addr=src ptr. On mem_ok: latch mem_din into mem_dout,
//   mem_cs=0 for at least one cen cycle, -> WR.
//  WR: mem_cs=1, mem_rnw=0, mem_addr=dst ptr. On mem_ok: src++, dst++, count--, tenure++;
//   mem_cs=0. count reaches 0 -> FIN; tenure==BURST -> REL; else -> RD.
//  REL: dev_br=0; wait until cpu_BGACKn==1 (arbiter freed bus), then -> REQ to re-request.
//  FIN: dev_br=0; wait until cpu_BGACKn==1 (skip wait if bus never requested);
//   then done=1 for one cen cycle, busy=0, -> IDLE.
//  dev_br drops in the same cen cycle the last WR mem_ok or BURST limit is seen.
//  Pointers increment modulo 2^AW (wrap from all-ones to 0, no error).
//  Ownership loss: if cpu_BGACKn goes 1 in RD/WR, the current cycle is allowed to finish
//   (mem_cs held to mem_ok); a completed read is kept, then state -> REQ and the copy resumes
//   at the pending RD or WR without re-reading. No word is lost or duplicated.
//  start while busy=1 is ignored; start coincident with done is ignored (busy still 1).
//  mem_cs is never asserted unless cpu_BGACKn==0 at cycle start.
//  cen=0: all outputs hold; mem_ok is not sampled.
// TESTING
//  1 src=0x100,dst=0x200,len=4, arbiter grants after 3 cycles -> 4 reads 0x100-0x103, 4 writes
//    0x200-0x203 with matching data, dev_br low after 4th write ok, single done pulse.
//  2 len=0 start -> done one cen later, dev_br never asserted, mem_cs never asserted.
//  3 BURST=4, len=10 -> three tenures (4,4,2 words), dev_br drops and waits for BGACKn=1
//    between tenures; destination contents equal source.
//  4 src=0x7FFFFE,len=4 (AW=23) -> reads at 0x7FFFFE,0x7FFFFF,0x000000,0x000001.
//  5 BGACKn forced 1 mid-RD with mem_ok delayed 5 cycles -> read completes, no new cycle until
//    re-grant, then WR of same data; total writes == len.
//  6 assert rst during WR of word 3 -> outputs at reset values immediately; new start works.

Source files
------------

// File: rtl/jtframe_68kdma_copy_if.sv
// Command and memory-bus bundle for the 68k DMA block-copy master.
interface jtframe_68kdma_copy_if #(
   parameter int AW = 23,
   parameter int DW = 16,
   parameter int LW = 12
);
   // start is a single-cen pulse, taken only while busy=0; a memory cycle is
   // offered by holding mem_cs high and completes on the first cen with mem_ok=1.
   logic          start;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic          dev_br;
   logic          cpu_BGACKn;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic [DW-1:0] mem_din;
   logic          mem_cs;
   logic          mem_rnw;
   logic          mem_ok;

   modport master (
      input  start, src, dst, len, cpu_BGACKn, mem_din, mem_ok,
      output busy, done, dev_br, mem_addr, mem_dout, mem_cs, mem_rnw
   );

   modport slave (
      output start, src, dst, len, cpu_BGACKn, mem_din, mem_ok,
      input  busy, done, dev_br, mem_addr, mem_dout, mem_cs, mem_rnw
   );
endinterface

// File: rtl/jtframe_68kdma_copy.sv
// DMA block-copy master: requests the 68k bus, copies words src->dst in
// bounded tenures and reports completion with a one-cen done pulse.
module jtframe_68kdma_copy #(
   parameter int AW    = 23,
   parameter int DW    = 16,
   parameter int LW    = 12,
   parameter int BURST = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cen,
   jtframe_68kdma_copy_if.master bus,
   output logic [2:0]          state_dbg
);
   localparam int TW = $clog2(BURST + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      REL  = 3'd4,
      FIN  = 3'd5
   } state_t;

   state_t        state;
   logic [AW-1:0] src_ptr;
   logic [AW-1:0] dst_ptr;
   logic [LW-1:0] count;
   logic [TW-1:0] tenure;
   logic          have_data;
   logic          requested;

   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         src_ptr      <= '0;
         dst_ptr      <= '0;
         count        <= '0;
         tenure       <= '0;
         have_data    <= 1'b0;
         requested    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.dev_br   <= 1'b0;
         bus.mem_cs   <= 1'b0;
         bus.mem_rnw  <= 1'b1;
         bus.mem_addr <= '0;
         bus.mem_dout <= '0;
      end else if (cen) begin
         case (state)
            IDLE: begin
               // busy stays high through the done cycle so a coincident start is dropped
               if (bus.done) begin
                  bus.done <= 1'b0;
                  bus.busy <= 1'b0;
               end else if (bus.start) begin
                  src_ptr   <= bus.src;
                  dst_ptr   <= bus.dst;
                  count     <= bus.len;
                  have_data <= 1'b0;
                  bus.busy  <= 1'b1;
                  if (bus.len == '0) begin
                     requested <= 1'b0;
                     state     <= FIN;
                  end else begin
                     requested  <= 1'b1;
                     bus.dev_br <= 1'b1;
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               if (!bus.cpu_BGACKn) begin
                  tenure <= '0;
                  state  <= have_data ? WR : RD;
               end
            end
            RD: begin
               // a cycle only opens from an idle slot that still sees ownership
               if (bus.mem_cs) begin
                  if (bus.mem_ok) begin
                     bus.mem_cs   <= 1'b0;
                     bus.mem_dout <= bus.mem_din;
                     have_data    <= 1'b1;
                     state        <= WR;
                  end
               end else if (bus.cpu_BGACKn) begin
                  state <= REQ;
               end else begin
                  bus.mem_cs   <= 1'b1;
                  bus.mem_rnw  <= 1'b1;
                  bus.mem_addr <= src_ptr;
               end
            end
            WR: begin
               if (bus.mem_cs) begin
                  if (bus.mem_ok) begin
                     bus.mem_cs <= 1'b0;
                     have_data  <= 1'b0;
                     src_ptr    <= src_ptr + 1'b1;
                     dst_ptr    <= dst_ptr + 1'b1;
                     count      <= count - 1'b1;
                     tenure     <= tenure + 1'b1;
                     if (count == LW'(1)) begin
                        bus.dev_br <= 1'b0;
                        state      <= FIN;
                     end else if (tenure == TW'(BURST - 1)) begin
                        bus.dev_br <= 1'b0;
                        state      <= REL;
                     end else begin
                        state <= RD;
                     end
                  end
               end else if (bus.cpu_BGACKn) begin
                  state <= REQ;
               end else begin
                  bus.mem_cs   <= 1'b1;
                  bus.mem_rnw  <= 1'b0;
                  bus.mem_addr <= dst_ptr;
               end
            end
            REL: begin
               if (bus.cpu_BGACKn) begin
                  bus.dev_br <= 1'b1;
                  state      <= REQ;
               end
            end
            FIN: begin
               if (!requested || bus.cpu_BGACKn) begin
                  bus.done <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_jtframe_68kdma_copy.sv
// Bench for jtframe_68kdma_copy: arbiter and memory responders plus a
// reference model of the expected read/write sequence for each copy.
module tb_jtframe_68kdma_copy;
   localparam int AW = 23, DW = 16, LW = 12, BURST = 4;

   logic       clk = 1'b0, rst = 1'b1, cen = 1'b0;
   logic [2:0] state_dbg;
   logic       bg_r = 1'b1, ok_r = 1'b0;
   logic [DW-1:0] din_r = '0;

   jtframe_68kdma_copy_if #(.AW(AW), .DW(DW), .LW(LW)) bus();

   jtframe_68kdma_copy #(.AW(AW), .DW(DW), .LW(LW), .BURST(BURST)) dut (
      .clk(clk), .rst(rst), .cen(cen), .bus(bus), .state_dbg(state_dbg)
   );

   assign bus.cpu_BGACKn = bg_r;
   assign bus.mem_ok     = ok_r;
   assign bus.mem_din    = din_r;

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [AW-1:0] rd_q[$], wr_a_q[$];
   logic [DW-1:0] wr_d_q[$];
   int  done_cnt = 0, d0 = 0, writes = 0, grants = 0, tenure_words = 0, exp_len = 0;
   bit  br_seen, cs_seen, chk_br, mon_en;
   logic prev_bg = 1'b1, prev_cs = 1'b0, prev_done = 1'b0;
   bit  force_cen, slow, steal_arm, steal_hold, steal_fired;
   int  steal_left, gdelay = 1, gwait, lat_cnt, cur_lat;

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return a[15:0] ^ {a[6:0], a[22:14]} ^ 16'h5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // clock enable, memory responder and bus arbiter, all driven 1 time unit after the edge
   always @(posedge clk) begin
      #1;
      cen = force_cen || ($urandom_range(0, 3) != 0);
      if (!bus.mem_cs) begin
         ok_r = 1'b0; lat_cnt = 0; cur_lat = slow ? 5 : $urandom_range(0, 2);
      end else if (!ok_r) begin
         if (lat_cnt >= cur_lat) begin
            ok_r  = 1'b1;
            din_r = bus.mem_rnw ? mem_rd(bus.mem_addr) : DW'($urandom);
         end else lat_cnt++;
      end
      if (steal_hold) begin
         if (bus.mem_cs) steal_left = 3;
         else if (cen) begin
            steal_left--;
            if (steal_left == 0) steal_hold = 1'b0;
         end
      end else if (steal_arm && bus.mem_cs && bus.mem_rnw && !ok_r && !bg_r) begin
         bg_r = 1'b1; steal_hold = 1'b1; steal_left = 3; steal_arm = 1'b0; steal_fired = 1'b1;
      end else if (bus.dev_br && bg_r) begin
         if (gwait >= gdelay) begin bg_r = 1'b0; gwait = 0; end
         else gwait++;
      end else begin
         gwait = 0;
         if (!bus.dev_br) bg_r = 1'b1;
      end
   end

   // bus monitor: completed cycles are matched against the expected sequence
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (chk_br) begin check("dev_br_drop", 32'(bus.dev_br), 32'd0); chk_br = 1'b0; end
         if (prev_bg && !bus.cpu_BGACKn) begin grants++; tenure_words = 0; end
         if (bus.mem_cs && !prev_cs) check("cs_needs_grant", 32'(prev_bg), 32'd0);
         if (bus.done && !prev_done) begin
            done_cnt++;
            check("busy_at_done", 32'(bus.busy), 32'd1);
         end
         br_seen |= bus.dev_br;
         cs_seen |= bus.mem_cs;
         if (cen && bus.mem_cs && bus.mem_ok) begin
            if (bus.mem_rnw) begin
               check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
               if (rd_q.size() != 0) check("rd_addr", 32'(bus.mem_addr), 32'(rd_q.pop_front()));
            end else begin
               check("wr_expected", 32'(wr_a_q.size() != 0), 32'd1);
               if (wr_a_q.size() != 0) begin
                  check("wr_addr", 32'(bus.mem_addr), 32'(wr_a_q.pop_front()));
                  check("wr_data", 32'(bus.mem_dout), 32'(wr_d_q.pop_front()));
               end
               mem[bus.mem_addr] = bus.mem_dout;
               writes++;
               tenure_words++;
               if (wr_a_q.size() == 0 || tenure_words == BURST) chk_br = 1'b1;
            end
         end
      end
      prev_bg = bus.cpu_BGACKn; prev_cs = bus.mem_cs; prev_done = bus.done;
   end

   task automatic chk_reset_vals(input string tag);
      check({tag, "_busy"},  32'(bus.busy),     32'd0);
      check({tag, "_done"},  32'(bus.done),     32'd0);
      check({tag, "_br"},    32'(bus.dev_br),   32'd0);
      check({tag, "_cs"},    32'(bus.mem_cs),   32'd0);
      check({tag, "_rnw"},   32'(bus.mem_rnw),  32'd1);
      check({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
      check({tag, "_dout"},  32'(bus.mem_dout), 32'd0);
      check({tag, "_state"}, 32'(state_dbg),    32'd0);
   endtask

   task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
      force_cen = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l;
      @(posedge clk); #2;
      bus.start = 1'b0;
      force_cen = 1'b0;
   endtask

   task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
      int t;
      logic [AW-1:0] a;
      t = 0;
      while (bus.busy && t < 500) begin @(negedge clk); t++; end
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
      for (int i = 0; i < int'(l); i++) begin
         a = s + AW'(i);
         rd_q.push_back(a);
         wr_a_q.push_back(d + AW'(i));
         wr_d_q.push_back(mem_rd(a));
      end
      d0 = done_cnt; writes = 0; grants = 0; br_seen = 1'b0; cs_seen = 1'b0; exp_len = int'(l);
      pulse_start(s, d, l);
   endtask

   task automatic finish_copy(input string tag, input int budget, input int exp_grants);
      int t;
      t = 0;
      while (done_cnt == d0 && t < budget) begin @(negedge clk); t++; end
      check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
      repeat (4) @(negedge clk);
      check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
      check({tag, "_wr_left"}, 32'(wr_a_q.size()), 32'd0);
      check({tag, "_writes"}, 32'(writes), 32'(exp_len));
      if (exp_grants >= 0) check({tag, "_grants"}, 32'(grants), 32'(exp_grants));
   endtask

   initial begin
      int t;
      logic [AW-1:0] s, d;
      logic [LW-1:0] l;
      bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
      mon_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #2 rst = 1'b0;
      mon_en = 1'b1;

      // basic copy with a fixed grant delay and an ignored start while busy
      gdelay = 3;
      do_start(23'h100, 23'h200, 12'd4);
      repeat (3) @(negedge clk);
      pulse_start(23'h555, 23'h666, 12'd3);
      finish_copy("t1", 3000, 1);

      // zero-length command never touches the bus
      gdelay = 1;
      do_start(23'h40, 23'h80, 12'd0);
      finish_copy("t2", 20, 0);
      check("t2_no_br", 32'(br_seen), 32'd0);
      check("t2_no_cs", 32'(cs_seen), 32'd0);

      // three tenures of 4,4,2 words
      gdelay = 2;
      do_start(23'h1000, 23'h2000, 12'd10);
      finish_copy("t3", 3000, 3);
      for (int i = 0; i < 10; i++)
         check("t3_dst_eq_src", 32'(mem_rd(23'h2000 + AW'(i))), 32'(mem_rd(23'h1000 + AW'(i))));

      // source pointer wraps past the top of the address space
      do_start(23'h7FFFFE, 23'h300, 12'd4);
      finish_copy("t4", 3000, 1);

      // ownership taken away during a slow read
      slow = 1'b1; steal_arm = 1'b1; steal_fired = 1'b0;
      do_start(23'h400, 23'h500, 12'd3);
      finish_copy("t5", 3000, -1);
      check("t5_steal_fired", 32'(steal_fired), 32'd1);
      slow = 1'b0; steal_arm = 1'b0;

      // asynchronous reset while the third write is in flight
      gdelay = 0;
      do_start(23'h600, 23'h700, 12'd8);
      t = 0;
      while (!(writes == 2 && bus.mem_cs && !bus.mem_rnw) && t < 3000) begin @(negedge clk); t++; end
      check("t6_reach_wr3", 32'(writes == 2 && bus.mem_cs && !bus.mem_rnw), 32'd1);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset_vals("t6_rst");
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete(); chk_br = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      do_start(23'h800, 23'h900, 12'd5);
      finish_copy("t6_after", 3000, 2);

      // randomized copies
      for (int k = 0; k < 6; k++) begin
         gdelay = $urandom_range(0, 3);
         s = AW'($urandom_range(0, (1 << AW) - 1));
         d = s + 23'h1000 + AW'($urandom_range(0, 12'hFFF));
         l = LW'($urandom_range(1, 20));
         do_start(s, d, l);
         finish_copy("rand", 4000, (int'(l) + BURST - 1) / BURST);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
